// File: rtl/tile_loader.sv
// Packs a word stream into LANES-wide rows for one half of a double buffer,
// then waits for the reader to free the other bank before swapping.
module tile_loader #(
    parameter int DATA_WIDTH      = 16,
    parameter int LANES           = 4,
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BANK_ADDR_WIDTH-1:0]    cfg_rows_m1,
    input  logic                          cfg_vld,
    output logic                          cfg_rdy,
    input  logic [DATA_WIDTH-1:0]         in_dat,
    input  logic                          in_last,
    input  logic                          in_vld,
    output logic                          in_rdy,
    output logic                          wen,
    output logic [BANK_ADDR_WIDTH-1:0]    wadr,
    output logic [DATA_WIDTH*LANES-1:0]   wdata,
    input  logic                          bank_free,
    output logic                          switch_banks,
    output logic                          busy,
    output logic [COUNT_WIDTH-1:0]        tile_count
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW = DATA_WIDTH * LANES;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_SWAP,
        SWAP
    } state_t;

    state_t state_q, state_d;

    logic [BANK_ADDR_WIDTH-1:0] rows_m1_q;
    logic [BANK_ADDR_WIDTH-1:0] row_q;
    logic [LW-1:0]              lane_q;
    logic [RW-1:0]              pack_q;
    logic [RW-1:0]              pack_d;
    logic                       accept;
    logic                       row_done;
    logic                       tile_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cfg_rdy      = 1'b0;
        in_rdy       = 1'b0;
        switch_banks = 1'b0;
        accept       = 1'b0;
        row_done     = 1'b0;
        tile_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_rdy = 1'b1;
                if (cfg_vld) state_d = FILL;
            end
            FILL: begin
                in_rdy   = 1'b1;
                accept   = in_vld;
                row_done = accept &&
                           (in_last || lane_q == LW'(LANES - 1));
                tile_done = row_done &&
                            (in_last || row_q == rows_m1_q);
                if (tile_done) state_d = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (bank_free) state_d = SWAP;
            end
            SWAP: begin
                switch_banks = 1'b1;
                state_d      = FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pack register is cleared after every row, so lanes left unfilled
    // by an early in_last are already zero.
    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == LW'(k)) begin
                pack_d[k*DATA_WIDTH +: DATA_WIDTH] = in_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_m1_q  <= '0;
            row_q      <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            wen        <= 1'b0;
            wadr       <= '0;
            wdata      <= '0;
            tile_count <= '0;
        end else begin
            wen <= row_done;
            if (state_q == IDLE && cfg_vld) begin
                rows_m1_q <= cfg_rows_m1;
                row_q     <= '0;
                lane_q    <= '0;
                pack_q    <= '0;
            end
            if (state_q == SWAP) begin
                row_q      <= '0;
                lane_q     <= '0;
                pack_q     <= '0;
                tile_count <= tile_count + COUNT_WIDTH'(1);
            end
            if (accept) begin
                if (row_done) begin
                    wadr   <= row_q;
                    wdata  <= pack_d;
                    pack_q <= '0;
                    lane_q <= '0;
                    row_q  <= row_q + BANK_ADDR_WIDTH'(1);
                end else begin
                    pack_q <= pack_d;
                    lane_q <= lane_q + LW'(1);
                end
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule
